// File: rtl/brlite_svc_rx_buffer.sv
// BrLite receive-side service buffer: four-phase req/ack intake from the router,
// service/target filtering, and a small FIFO presented to the NI with a pop pulse.
package brlite_svc_rx_buffer_pkg;
  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] seq_target;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;

  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

  localparam logic [1:0] SVC_ALL     = 2'b00;
  localparam logic [1:0] SVC_TARGET  = 2'b01;
  localparam logic [1:0] SVC_MONITOR = 2'b10;
  localparam logic [1:0] SVC_CLEAR   = 2'b11;
endpackage

// Router side: br_req_i rises with br_data_i stable; the packet is consumed on the
// edge that raises br_ack_o, and br_ack_o stays high until br_req_i drops.
// NI side: br_svc_data_o is valid while br_svc_rx_o=1; a one-cycle br_svc_ack_i pops it.
module brlite_svc_rx_buffer
  import brlite_svc_rx_buffer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] ADDRESS    = 16'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         br_req_i,
  output logic                         br_ack_o,
  input  brlite_out_t                  br_data_i,
  output logic                         br_svc_rx_o,
  input  logic                         br_svc_ack_i,
  output brlite_svc_t                  br_svc_data_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic [15:0]                  drop_cnt_o,
  output logic                         fsm_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  brlite_svc_t mem [FIFO_DEPTH];

  logic full;
  logic is_enq;
  logic push;
  logic discard;
  logic pop;

  assign full   = (count_o == FULL_COUNT);
  assign is_enq = (br_data_i.service == SVC_ALL) ||
                  ((br_data_i.service == SVC_TARGET) &&
                   (br_data_i.seq_target[7:0] == ADDRESS[7:0]));

  // A full FIFO only holds off enqueue-class packets; discards are always acked.
  assign push    = (state == S_IDLE) && br_req_i && is_enq && !full;
  assign discard = (state == S_IDLE) && br_req_i && !is_enq;
  assign pop     = br_svc_ack_i && (count_o != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      drop_cnt_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (push || discard) state <= S_HOLD;
        S_HOLD: if (!br_req_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count_o <= count_o + (PW + 1)'(1);
        2'b01:   count_o <= count_o - (PW + 1)'(1);
        default: count_o <= count_o;
      endcase

      if (discard && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= '{ksvc:       br_data_i.ksvc,
                       seq_source: br_data_i.seq_target,
                       producer:   br_data_i.producer,
                       payload:    br_data_i.payload};
    end
  end

  assign br_ack_o      = (state == S_HOLD);
  assign fsm_state_o   = (state == S_HOLD);
  assign br_svc_rx_o   = (count_o != '0);
  assign br_svc_data_o = mem[rd_ptr];

endmodule

// File: tb/tb_brlite_svc_rx_buffer.sv
// Bench for brlite_svc_rx_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the accept/drop/pop rules.
module tb_brlite_svc_rx_buffer;
  import brlite_svc_rx_buffer_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] ADDR   = 16'h0035;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam int          BUDGET = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          br_req;
  logic          br_ack;
  brlite_out_t   br_data;
  logic          br_svc_rx;
  logic          br_svc_ack;
  brlite_svc_t   br_svc_data;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          fsm_state;

  brlite_svc_rx_buffer #(.FIFO_DEPTH(DEPTH), .ADDRESS(ADDR)) dut (
    .clk_i(clk), .rst_i(rst), .br_req_i(br_req), .br_ack_o(br_ack),
    .br_data_i(br_data), .br_svc_rx_o(br_svc_rx), .br_svc_ack_i(br_svc_ack),
    .br_svc_data_o(br_svc_data), .count_o(count), .drop_cnt_o(drop_cnt),
    .fsm_state_o(fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [71:0] exp_q[$];
  logic [15:0] exp_drop;
  int n_cmp = 0;
  int n_err = 0;

  function automatic brlite_out_t mk(logic [1:0] svc, logic [7:0] k, logic [7:0] tgt,
                                     logic [15:0] prod, logic [31:0] pl);
    brlite_out_t p;
    p.service    = svc;
    p.ksvc       = k;
    p.seq_target = {8'($urandom_range(0, 255)), tgt};
    p.producer   = prod;
    p.payload    = pl;
    return p;
  endfunction

  function automatic bit accepts(brlite_out_t p);
    return (p.service == 2'b00) || ((p.service == 2'b01) && (p.seq_target[7:0] == ADDR[7:0]));
  endfunction

  function automatic logic [71:0] to_svc(brlite_out_t p);
    return {p.ksvc, p.seq_target, p.producer, p.payload};
  endfunction

  function automatic brlite_out_t rand_pkt();
    logic [7:0] tgt;
    tgt = ($urandom_range(0, 1) == 1) ? ADDR[7:0] : 8'($urandom_range(0, 255));
    return mk(2'($urandom_range(0, 3)), 8'($urandom), tgt, 16'($urandom), 32'($urandom));
  endfunction

  // ---------------- driver tasks ----------------
  // Raises req and waits for ack; lat = cycles to ack, or -1 if the budget ran out.
  task automatic send_pkt(input brlite_out_t p, output int lat);
    br_data = p;
    br_req  = 1'b1;
    lat     = -1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk); #1;
      if (br_ack === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat > 0) begin
      if (accepts(p)) exp_q.push_back(to_svc(p));
      else if (exp_drop != 16'hFFFF) exp_drop++;
    end
  endtask

  task automatic release_req();
    br_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    br_svc_ack = 1'b1;
    @(posedge clk); #1;
    br_svc_ack = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; br_req = 1'b0; br_svc_ack = 1'b0; br_data = '0;
    exp_q.delete(); exp_drop = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (br_ack !== 1'b0)    begin n_err++; $display("FAIL reset_ack: got %b expected 0", br_ack); end
    n_cmp++; if (br_svc_rx !== 1'b0) begin n_err++; $display("FAIL reset_rx: got %b expected 0", br_svc_rx); end
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    n_cmp++; if (fsm_state !== 1'b0) begin n_err++; $display("FAIL reset_state: got %b expected 0", fsm_state); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (br_ack !== 1'b0)    begin n_err++; $display("FAIL post_reset_ack: got %b expected 0", br_ack); end
  endtask

  task automatic test_single();
    brlite_out_t p;
    int lat;
    p = mk(2'b00, 8'h21, 8'h00, 16'h0102, 32'hDEADBEEF);
    send_pkt(p, lat);
    n_cmp++; if (lat != 1)           begin n_err++; $display("FAIL single_latency: got %0d expected 1", lat); end
    n_cmp++; if (br_svc_rx !== 1'b1) begin n_err++; $display("FAIL single_rx: got %b expected 1", br_svc_rx); end
    n_cmp++; if (count !== CW'(1))   begin n_err++; $display("FAIL single_count: got %0d expected 1", count); end
    n_cmp++; if (br_svc_data !== {8'h21, p.seq_target, 16'h0102, 32'hDEADBEEF})
      begin n_err++; $display("FAIL single_data: got %h expected %h", br_svc_data, {8'h21, p.seq_target, 16'h0102, 32'hDEADBEEF}); end
    release_req();
    n_cmp++; if (br_ack !== 1'b0)    begin n_err++; $display("FAIL single_ack_release: got %b expected 0", br_ack); end
    pop_one();
    n_cmp++; if (br_svc_rx !== 1'b0) begin n_err++; $display("FAIL single_pop_rx: got %b expected 0", br_svc_rx); end
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL single_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_target();
    brlite_out_t p;
    int lat;
    p = mk(2'b01, 8'h33, ADDR[7:0], 16'h0A0B, 32'h12345678);
    send_pkt(p, lat);
    n_cmp++; if (lat != 1)         begin n_err++; $display("FAIL target_latency: got %0d expected 1", lat); end
    n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL target_count: got %0d expected 1", count); end
    n_cmp++; if (br_svc_data !== to_svc(p))
      begin n_err++; $display("FAIL target_data: got %h expected %h", br_svc_data, to_svc(p)); end
    release_req();
    pop_one();
    n_cmp++; if (count !== '0)     begin n_err++; $display("FAIL target_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_drops();
    brlite_out_t p;
    int lat;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       p = mk(2'b01, 8'h40, ADDR[7:0] ^ 8'h01, 16'h1111, 32'h0);
        1:       p = mk(2'b10, 8'h41, ADDR[7:0], 16'h2222, 32'h1);
        default: p = mk(2'b11, 8'h42, ADDR[7:0], 16'h3333, 32'h2);
      endcase
      send_pkt(p, lat);
      n_cmp++; if (lat != 1)           begin n_err++; $display("FAIL drop_latency[%0d]: got %0d expected 1", i, lat); end
      n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL drop_count[%0d]: got %0d expected 0", i, count); end
      n_cmp++; if (br_svc_rx !== 1'b0) begin n_err++; $display("FAIL drop_rx[%0d]: got %b expected 0", i, br_svc_rx); end
      release_req();
    end
    n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL drop_cnt: got %0d expected 3", drop_cnt); end
  endtask

  task automatic test_full();
    brlite_out_t p;
    int lat;
    for (int i = 1; i <= 4; i++) begin
      send_pkt(mk(2'b00, 8'(i), 8'h00, 16'h0F00, 32'(i)), lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL fill_latency[%0d]: got %0d expected 1", i, lat); end
      release_req();
    end
    n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL fill_count: got %0d expected 4", count); end
    p = mk(2'b00, 8'h05, 8'h00, 16'h0F00, 32'd5);
    br_data = p;
    br_req  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (br_ack !== 1'b0)  begin n_err++; $display("FAIL full_no_ack[%0d]: got %b expected 0", c, br_ack); end
      n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL full_count[%0d]: got %0d expected 4", c, count); end
    end
    pop_one();
    n_cmp++; if (br_ack !== 1'b0)  begin n_err++; $display("FAIL full_pop_same_cycle_ack: got %b expected 0", br_ack); end
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL full_pop_count: got %0d expected 3", count); end
    @(posedge clk); #1;
    n_cmp++; if (br_ack !== 1'b1)  begin n_err++; $display("FAIL full_next_accept: got %b expected 1", br_ack); end
    n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL full_refill_count: got %0d expected 4", count); end
    exp_q.push_back(to_svc(p));
    release_req();
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (br_svc_data.payload !== 32'(i))
        begin n_err++; $display("FAIL drain_order: got %0d expected %0d", br_svc_data.payload, i); end
      pop_one();
    end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    brlite_out_t p;
    int lat;
    for (int i = 0; i < 2; i++) begin
      send_pkt(mk(2'b00, 8'($urandom), 8'h00, 16'($urandom), 32'($urandom)), lat);
      release_req();
    end
    n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL b2b_pre_count: got %0d expected 2", count); end
    p = mk(2'b00, 8'h77, 8'h00, 16'h7777, 32'h77777777);
    br_data = p; br_req = 1'b1; br_svc_ack = 1'b1;
    @(posedge clk); #1;
    br_svc_ack = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(to_svc(p));
    n_cmp++; if (br_ack !== 1'b1)  begin n_err++; $display("FAIL b2b_ack: got %b expected 1", br_ack); end
    n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", count); end
    release_req();
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (br_svc_data !== exp_q[0])
        begin n_err++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, br_svc_data, exp_q[0]); end
      pop_one();
    end
  endtask

  task automatic test_pop_empty();
    brlite_out_t p;
    int lat;
    pop_one();
    pop_one();
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
    n_cmp++; if (br_svc_rx !== 1'b0) begin n_err++; $display("FAIL empty_pop_rx: got %b expected 0", br_svc_rx); end
    p = mk(2'b00, 8'h5A, 8'h00, 16'h5A5A, 32'hA5A5A5A5);
    send_pkt(p, lat);
    n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL empty_then_push_count: got %0d expected 1", count); end
    n_cmp++; if (br_svc_data !== to_svc(p))
      begin n_err++; $display("FAIL empty_then_push_data: got %h expected %h", br_svc_data, to_svc(p)); end
    release_req();
    pop_one();
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 80; i++) begin
      if (($urandom_range(0, 2) == 0) || (exp_q.size() == DEPTH)) begin
        pop_one();
      end else begin
        send_pkt(rand_pkt(), lat);
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected 1", i, lat); end
        release_req();
      end
      n_cmp++; if (count !== CW'(exp_q.size()))
        begin n_err++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, exp_q.size()); end
      n_cmp++; if (br_svc_rx !== (exp_q.size() != 0))
        begin n_err++; $display("FAIL rand_rx[%0d]: got %b expected %b", i, br_svc_rx, exp_q.size() != 0); end
      n_cmp++; if (drop_cnt !== exp_drop)
        begin n_err++; $display("FAIL rand_drop[%0d]: got %0d expected %0d", i, drop_cnt, exp_drop); end
      if (exp_q.size() != 0) begin
        n_cmp++; if (br_svc_data !== exp_q[0])
          begin n_err++; $display("FAIL rand_head[%0d]: got %h expected %h", i, br_svc_data, exp_q[0]); end
      end
    end
    while (exp_q.size() != 0) pop_one();
  endtask

  task automatic test_reset_mid();
    brlite_out_t p;
    int lat;
    for (int i = 0; i < 2; i++) begin
      send_pkt(mk(2'b00, 8'($urandom), 8'h00, 16'($urandom), 32'($urandom)), lat);
      release_req();
    end
    p = mk(2'b00, 8'h99, 8'h00, 16'h9999, 32'h99999999);
    send_pkt(p, lat);
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL mid_pre_count: got %0d expected 3", count); end
    n_cmp++; if (br_ack !== 1'b1)  begin n_err++; $display("FAIL mid_pre_ack: got %b expected 1", br_ack); end
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_drop = '0;
    n_cmp++; if (br_ack !== 1'b0)    begin n_err++; $display("FAIL mid_rst_ack: got %b expected 0", br_ack); end
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    n_cmp++; if (br_svc_rx !== 1'b0) begin n_err++; $display("FAIL mid_rst_rx: got %b expected 0", br_svc_rx); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(to_svc(p));
    n_cmp++; if (br_ack !== 1'b1)    begin n_err++; $display("FAIL mid_reaccept_ack: got %b expected 1", br_ack); end
    n_cmp++; if (count !== CW'(1))   begin n_err++; $display("FAIL mid_reaccept_count: got %0d expected 1", count); end
    n_cmp++; if (br_svc_data !== to_svc(p))
      begin n_err++; $display("FAIL mid_reaccept_data: got %h expected %h", br_svc_data, to_svc(p)); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL mid_reaccept_drop: got %0d expected 0", drop_cnt); end
    release_req();
    pop_one();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_target();
    test_drops();
    test_full();
    test_back_to_back();
    test_pop_empty();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
